// File: rtl/de2_input_pkg.sv
// Shared constants, event layout and sizing helper for the DE2 input controller.
// Pure declarations; no timing and no handshake of its own.
package de2_input_pkg;

  localparam int DEF_NUM_BUTTONS     = 2;
  localparam int DEF_SW_WIDTH        = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 32;
  localparam int DEF_FIFO_DEPTH      = 4;

  // Index width that stays legal (>= 1 bit) for single-entry ranges.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_BTN_W = ptr_w(DEF_NUM_BUTTONS);

  typedef struct packed {
    logic [DEF_BTN_W-1:0]    button;
    logic [DEF_SW_WIDTH-1:0] sw;
  } evt_t;

endpackage

// File: rtl/input_debounce.sv
// 2-flop synchroniser plus counter debouncer; a new level is accepted after
// DEBOUNCE_CYCLES consecutive differing samples, 2 sync cycles + that count of latency, no backpressure.
module input_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 32
) (
  input  logic             i_core_clk,
  input  logic             i_arst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge i_core_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Whole vector shares one counter: any bit change restarts the count.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/de2_input_ctrl.sv
// Debounced DE2 key/switch front end queuing {button, switches} press events;
// press-to-evt_valid is DEBOUNCE_CYCLES+4 cycles, a full queue parks the press as pending, a second press on a pending button sets overflow.
module de2_input_ctrl
  import de2_input_pkg::*;
#(
  parameter int NUM_BUTTONS     = DEF_NUM_BUTTONS,
  parameter int SW_WIDTH        = DEF_SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                          CLOCK_50,
  input  logic                          nReset,
  input  logic [NUM_BUTTONS-1:0]        KEY_n,
  input  logic [SW_WIDTH-1:0]           SW,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [ptr_w(NUM_BUTTONS)-1:0] evt_button,
  output logic [SW_WIDTH-1:0]           evt_sw,
  output logic [SW_WIDTH-1:0]           sw_stable,
  output logic [NUM_BUTTONS-1:0]        btn_level,
  output logic                          overflow,
  input  logic                          ovf_clear
);

  localparam int BW = ptr_w(NUM_BUTTONS);
  localparam int PW = ptr_w(FIFO_DEPTH);

  typedef struct packed {
    logic [BW-1:0]       button;
    logic [SW_WIDTH-1:0] sw;
  } fifo_ent_t;

  logic [NUM_BUTTONS-1:0] w_btn_stable;
  logic [SW_WIDTH-1:0]    w_sw_stable;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    input_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_core_clk(CLOCK_50),
      .i_arst_n  (nReset),
      .i_raw     (~KEY_n[g]),
      .o_stable  (w_btn_stable[g])
    );
  end

  input_debounce #(.WIDTH(SW_WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .i_core_clk(CLOCK_50),
    .i_arst_n  (nReset),
    .i_raw     (SW),
    .o_stable  (w_sw_stable)
  );

  logic [NUM_BUTTONS-1:0] r_btn_level;
  logic [NUM_BUTTONS-1:0] r_btn_prev;
  logic [SW_WIDTH-1:0]    r_sw_stable;
  logic [NUM_BUTTONS-1:0] r_pending;
  logic [SW_WIDTH-1:0]    r_snap [NUM_BUTTONS];
  logic                   r_overflow;
  fifo_ent_t              r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW:0]            r_count;

  logic [NUM_BUTTONS-1:0] w_rise;
  logic [NUM_BUTTONS-1:0] w_clr;
  logic                   w_push_vld;
  logic [BW-1:0]          w_push_idx;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_ovf_set;
  fifo_ent_t              w_push_ent;

  assign w_rise = r_btn_level & ~r_btn_prev;

  // Lowest-index pending button wins; fullness uses the pre-pop count.
  always_comb begin
    w_push_vld = 1'b0;
    w_push_idx = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_push_vld = 1'b1;
        w_push_idx = BW'(i);
      end
    end
    w_push = w_push_vld && (r_count < (PW+1)'(FIFO_DEPTH));
    w_clr  = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_clr[i] = w_push && (w_push_idx == BW'(i));
    end
    w_push_ent.button = w_push_idx;
    w_push_ent.sw     = r_snap[w_push_idx];
    w_ovf_set         = |(w_rise & r_pending & ~w_clr);
  end

  assign w_pop = evt_valid && evt_ready;

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      r_btn_level <= '0;
      r_btn_prev  <= '0;
      r_sw_stable <= '0;
      r_pending   <= '0;
      r_overflow  <= 1'b0;
      for (int i = 0; i < NUM_BUTTONS; i++) r_snap[i] <= '0;
    end else begin
      r_btn_level <= w_btn_stable;
      r_btn_prev  <= r_btn_level;
      r_sw_stable <= w_sw_stable;
      r_overflow  <= (r_overflow && !ovf_clear) || w_ovf_set;
      // A press on a still-pending button keeps the original snapshot.
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (w_rise[i] && (!r_pending[i] || w_clr[i])) begin
          r_pending[i] <= 1'b1;
          r_snap[i]    <= r_sw_stable;
        end else if (w_clr[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_ent;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign evt_valid  = (r_count != '0);
  assign evt_button = r_mem[r_rd_ptr].button;
  assign evt_sw     = r_mem[r_rd_ptr].sw;
  assign sw_stable  = r_sw_stable;
  assign btn_level  = r_btn_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_de2_input_ctrl.sv
// Scoreboard bench for de2_input_ctrl: expected events are queued as presses are driven
// and compared against each accepted handshake.
module tb_de2_input_ctrl;
  import de2_input_pkg::*;

  logic        CLOCK_50;
  logic        nReset;
  logic [1:0]  KEY_n;
  logic [15:0] SW;
  logic        evt_valid;
  logic        evt_ready;
  logic [0:0]  evt_button;
  logic [15:0] evt_sw;
  logic [15:0] sw_stable;
  logic [1:0]  btn_level;
  logic        overflow;
  logic        ovf_clear;

  de2_input_ctrl dut (
    .CLOCK_50  (CLOCK_50),
    .nReset    (nReset),
    .KEY_n     (KEY_n),
    .SW        (SW),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_button(evt_button),
    .evt_sw    (evt_sw),
    .sw_stable (sw_stable),
    .btn_level (btn_level),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_evt = 0;
  int   vld_cycles = 0;
  evt_t exp_q [$];
  int   ev_cyc [$];

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic exp_push(input int b, input logic [15:0] sw);
    evt_t e;
    e.button = DEF_BTN_W'(b);
    e.sw     = sw;
    exp_q.push_back(e);
  endtask

  // Scoreboard side: every accepted handshake pops one expected event.
  always @(negedge CLOCK_50) begin
    if (nReset) begin
      if (evt_valid) vld_cycles++;
      if (evt_valid && evt_ready) begin
        n_evt++;
        ev_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_evt", 32'd1, 32'd0);
        end else begin
          evt_t e;
          e = exp_q.pop_front();
          chk("evt_button", 32'(evt_button), 32'(e.button));
          chk("evt_sw", 32'(evt_sw), 32'(e.sw));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic seen;
    nReset    = 1'b0;
    KEY_n     = 2'b11;
    SW        = 16'h0000;
    evt_ready = 1'b0;
    ovf_clear = 1'b0;
    step(3);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_sw_stable", 32'(sw_stable), 32'd0);
    chk("rst_btn_level", 32'(btn_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_evt_button", 32'(evt_button), 32'd0);
    chk("rst_evt_sw", 32'(evt_sw), 32'd0);

    // Reset release and switch change together; next edge is sample cycle 0.
    nReset = 1'b1;
    SW     = 16'h0001;
    vld_cycles = 0;
    step(34);
    chk("sw_stable_early", 32'(sw_stable), 32'd0);
    step(1);
    chk("sw_stable_c34", 32'(sw_stable), 32'h0001);
    step(10);
    chk("sw_no_evt", 32'(vld_cycles), 32'd0);

    // Single press: evt_valid must appear exactly 36 edges after the first low sample.
    evt_ready  = 1'b1;
    vld_cycles = 0;
    exp_push(0, 16'h0001);
    KEY_n[0] = 1'b0;
    step(36);
    chk("lat_evt_valid_c35", 32'(evt_valid), 32'd0);
    step(1);
    chk("lat_evt_valid_c36", 32'(evt_valid), 32'd1);
    chk("press_btn_level", 32'(btn_level), 32'h1);
    step(13);
    KEY_n[0] = 1'b1;
    step(60);
    chk("press_vld_cycles", 32'(vld_cycles), 32'd1);
    chk("release_btn_level", 32'(btn_level), 32'd0);

    // Short glitch on button 1.
    n0   = n_evt;
    seen = 1'b0;
    KEY_n[1] = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (i == 10) KEY_n[1] = 1'b1;
      seen |= btn_level[1];
      step(1);
    end
    chk("glitch_btn_level", 32'(seen), 32'd0);
    chk("glitch_no_evt", 32'(n_evt - n0), 32'd0);

    // Simultaneous presses: lowest index first, back-to-back.
    SW = 16'h0003;
    step(40);
    n0 = n_evt;
    ev_cyc.delete();
    exp_push(0, 16'h0003);
    exp_push(1, 16'h0003);
    KEY_n = 2'b00;
    step(50);
    KEY_n = 2'b11;
    step(60);
    chk("dual_evt_count", 32'(n_evt - n0), 32'd2);
    if (ev_cyc.size() == 2) chk("dual_consecutive", 32'(ev_cyc[1] - ev_cyc[0]), 32'd1);
    else chk("dual_cyc_count", 32'(ev_cyc.size()), 32'd2);

    // Fill FIFO, park one pending, overflow on the sixth press.
    evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) exp_push(0, 16'h0003);
      KEY_n[0] = 1'b0;
      step(40);
      KEY_n[0] = 1'b1;
      step(40);
      if (k == 4) chk("ovf_before_6th", 32'(overflow), 32'd0);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("full_evt_valid", 32'(evt_valid), 32'd1);
    n0 = n_evt;
    evt_ready = 1'b1;
    step(20);
    chk("drain_count", 32'(n_evt - n0), 32'd5);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clear = 1'b1;
    step(1);
    ovf_clear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Reset with queued events discards them at once.
    evt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_push(0, 16'h0003);
      KEY_n[0] = 1'b0;
      step(40);
      KEY_n[0] = 1'b1;
      step(40);
    end
    chk("pre_rst_evt_valid", 32'(evt_valid), 32'd1);
    #3;
    nReset = 1'b0;
    #1;
    chk("async_rst_evt_valid", 32'(evt_valid), 32'd0);
    exp_q.delete();
    step(3);
    nReset    = 1'b1;
    evt_ready = 1'b1;
    n0 = n_evt;
    step(100);
    chk("post_rst_no_evt", 32'(n_evt - n0), 32'd0);
    chk("post_rst_overflow", 32'(overflow), 32'd0);
    exp_push(0, 16'h0003);
    KEY_n[0] = 1'b0;
    step(50);
    KEY_n[0] = 1'b1;
    step(60);
    chk("post_rst_new_evt", 32'(n_evt - n0), 32'd1);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/de2_input_ctrl.md
Name: de2_input_ctrl

Overview:
- Board-level input controller between the DE2 switches/keys and the SoC.
- Synchronises and debounces the raw KEY and SW inputs, and detects button presses.
- Captures the debounced switch value at each press.
- Queues {button, switches} events in a small FIFO, drained by the SoC-side consumer over a valid/ready handshake.

Parameters:
- NUM_BUTTONS, 2, number of active-low push buttons handled.
- SW_WIDTH, 16, switch vector width.
- DEBOUNCE_CYCLES, 32, consecutive stable cycles needed to accept a new level (0.64 us at 50 MHz).
- FIFO_DEPTH, 4, event queue entries (power of two).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- nReset  in  1  asynchronous, active-low reset
- KEY_n  in  NUM_BUTTONS  raw buttons, active low, asynchronous
- SW  in  SW_WIDTH  raw switches, asynchronous
- evt_valid  out  1  head event available
- evt_ready  in  1  consumer accepts head event
- evt_button  out  $clog2(NUM_BUTTONS)  index of pressed button
- evt_sw  out  SW_WIDTH  debounced switch value captured at press
- sw_stable  out  SW_WIDTH  current debounced switch level
- btn_level  out  NUM_BUTTONS  debounced pressed level (1 = pressed)
- overflow  out  1  sticky lost-press flag
- ovf_clear  in  1  clears overflow

Behaviour:
- Clock and reset: one clock, CLOCK_50; reset nReset is asynchronous, active-low. Reset is asynchronous to everything; no other reset source.
- Reset values: sync flops hold "released" (pressed = 0) and SW = 0. sw_stable = 0, btn_level = 0, all counters = 0, pending = 0, FIFO empty, evt_valid = 0, evt_button = 0, evt_sw = 0, overflow = 0.
- Reset mid-operation: all queued and pending events are discarded immediately.
- Synchronisation: each KEY_n bit (inverted to pressed) and the whole SW vector pass through a 2-flop synchroniser.
- Debounce, per button:
  - Counter cleared whenever the sync value equals the stable value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the sync value still differs, the stable value updates on that edge and the counter clears.
- Debounce, SW: one counter for the whole vector, same rule. Any bit change restarts the count.
- Press detect: stable 0->1 on button i sets pending[i] and loads snap[i] <= sw_stable on the next edge.
- Release events: none; releases only update btn_level.
- Pending already set when a new press edge arrives: set overflow; keep the old snap.
- Arbitration: each cycle, the lowest-index pending button is pushed if the FIFO count < FIFO_DEPTH. The push clears its pending bit. One push per cycle.
- Push when full: blocked even if a pop occurs the same cycle; the push retries next cycle.
- Pop: when evt_valid && evt_ready. evt_* outputs show the registered FIFO head, stable while evt_valid && !evt_ready.
- Latency, with an empty FIFO and no competing pending: the first edge sampling KEY_n low is cycle 0.
  - Stable pressed at cycle DEBOUNCE_CYCLES+2.
  - pending at cycle +3.
  - evt_valid at cycle DEBOUNCE_CYCLES+4.
- Glitch filtering: a low pulse shorter than DEBOUNCE_CYCLES cycles produces no event and no btn_level change.
- overflow clears on ovf_clear. If set and cleared in the same cycle, set wins.

Decomposition:
- Package de2_input_pkg holds:
  - event struct typedef: button index + switch snapshot;
  - default parameter constants;
  - FIFO pointer width function.
- Sub-module input_debounce (parameter WIDTH, DEBOUNCE_CYCLES): synchroniser, counter and stable register. Instantiated once per button and once for SW.
- FIFO and arbiter stay inline.

Test Plan:
- Reset, then SW = 16'h0001 held, DEBOUNCE_CYCLES = 32 -> sw_stable = 16'h0001 by cycle 34 after release of reset; evt_valid stays 0.
- KEY_n[0] low 50 cycles, evt_ready = 1 -> evt_valid high exactly 1 cycle, 36 cycles after the first low sample, evt_button = 0, evt_sw = 16'h0001.
- KEY_n[1] low 10 cycles -> no event; btn_level[1] stays 0.
- SW = 16'h0003 stable, both keys low in the same cycle, evt_ready = 1 -> two events on consecutive cycles: button 0 then button 1, both evt_sw = 16'h0003.
- evt_ready = 0, six separated presses of button 0 -> FIFO holds 4 and one pending, 6th press sets overflow. Then evt_ready = 1 -> exactly 5 events drain; ovf_clear -> overflow = 0.
- nReset low while evt_valid = 1 with 3 queued -> evt_valid = 0 immediately. After release, no events until a new press.
